// File: rtl/tp8_pkg.sv
// Shared parameters and FSM state encodings for the data-logger capture buffer.
package tp8_pkg;

   localparam int NB_ADDR_MEM_DEF = 15;
   localparam int NB_DATA_DEF     = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FULL    = 2'd2
   } state_e;

endpackage

// File: rtl/log_ram.sv
// Capture RAM: one synchronous write port, one asynchronous read port, no reset.
module log_ram #(
   parameter int NB_ADDR = 15,
   parameter int NB_DATA = 32
) (
   input  logic               clk,
   input  logic               we,
   input  logic [NB_ADDR-1:0] waddr,
   input  logic [NB_DATA-1:0] wdata,
   input  logic [NB_ADDR-1:0] raddr,
   output logic [NB_DATA-1:0] rdata
);

   logic [NB_DATA-1:0] mem [0:(2**NB_ADDR)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/log_mem_ctrl.sv
// Capture controller: fills log_ram on i_valid strobes after i_run_log until full,
// then exposes the buffer to the register file through a combinational read.
module log_mem_ctrl
   import tp8_pkg::*;
#(
   parameter int NB_ADDR_MEM = NB_ADDR_MEM_DEF,
   parameter int NB_DATA     = NB_DATA_DEF
) (
   input  logic                   clk,
   input  logic                   i_rst_n,
   input  logic                   i_run_log,
   input  logic                   i_read_log,
   input  logic [NB_ADDR_MEM-1:0] i_addr_log,
   input  logic                   i_valid,
   input  logic [NB_DATA-1:0]     i_data_to_log,
   output logic [NB_DATA-1:0]     o_data_log,
   output logic                   o_mem_full,
   output logic                   o_busy,
   output logic [NB_ADDR_MEM:0]   o_wr_count
);

   state_e                 state_q, state_d;
   logic [NB_ADDR_MEM-1:0] wr_ptr_q, wr_ptr_d;
   logic [NB_ADDR_MEM:0]   wr_count_q, wr_count_d;
   logic                   full_q, busy_q;
   logic                   wr_en;
   logic [NB_DATA-1:0]     ram_rdata;

   // Read strobe only feeds a debug counter in the register file; data path ignores it.
   logic read_unused;
   assign read_unused = i_read_log;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      wr_count_d = wr_count_q;
      wr_en      = 1'b0;
      if (i_run_log) begin
         // Restart wins over a coincident strobe; that sample is dropped.
         state_d    = ST_CAPTURE;
         wr_ptr_d   = '0;
         wr_count_d = '0;
      end else begin
         unique case (state_q)
            ST_CAPTURE: begin
               if (i_valid) begin
                  wr_en      = 1'b1;
                  wr_count_d = wr_count_q + 1'b1;
                  if (wr_ptr_q == '1) state_d  = ST_FULL;
                  else                wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
            ST_FULL: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         wr_count_q <= '0;
         full_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_count_q <= wr_count_d;
         full_q     <= (state_d == ST_FULL);
         busy_q     <= (state_d == ST_CAPTURE);
      end
   end

   log_ram #(
      .NB_ADDR (NB_ADDR_MEM),
      .NB_DATA (NB_DATA)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (i_data_to_log),
      .raddr (i_addr_log),
      .rdata (ram_rdata)
   );

   // Buffer is only visible once complete; partial captures read as zero.
   assign o_data_log = (state_q == ST_FULL) ? ram_rdata : '0;
   assign o_mem_full = full_q;
   assign o_busy     = busy_q;
   assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Bench for log_mem_ctrl at DEPTH=16: vector table, corner sequences, random vs. model.
module tb_log_mem_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          i_rst_n;
   logic          i_run_log, i_read_log, i_valid;
   logic [AW-1:0] i_addr_log;
   logic [DW-1:0] i_data_to_log;
   logic [DW-1:0] o_data_log;
   logic          o_mem_full, o_busy;
   logic [AW:0]   o_wr_count;

   always #5 clk = ~clk;

   log_mem_ctrl #(.NB_ADDR_MEM(AW), .NB_DATA(DW)) dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .i_run_log     (i_run_log),
      .i_read_log    (i_read_log),
      .i_addr_log    (i_addr_log),
      .i_valid       (i_valid),
      .i_data_to_log (i_data_to_log),
      .o_data_log    (o_data_log),
      .o_mem_full    (o_mem_full),
      .o_busy        (o_busy),
      .o_wr_count    (o_wr_count)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model: capture in progress, finished flag, words taken, stored words.
   int          m_cnt;
   bit          m_cap, m_full;
   logic [DW-1:0] m_mem [DEPTH];

   typedef struct {
      bit            run;
      bit            valid;
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      bit            e_full;
      bit            e_busy;
      int            e_cnt;
      logic [DW-1:0] e_dout;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_cap = 0; m_full = 0;
   endtask

   task automatic model_step(input bit run, input bit valid, input logic [DW-1:0] data);
      if (run) begin
         m_cnt = 0; m_cap = 1; m_full = 0;
      end else if (m_cap && valid) begin
         m_mem[m_cnt] = data;
         m_cnt++;
         if (m_cnt == DEPTH) begin m_cap = 0; m_full = 1; end
      end
   endtask

   // Drive one cycle's inputs, clock it, advance the model, settle past the edge.
   task automatic cyc(input bit run, input bit valid, input logic [DW-1:0] data,
                      input logic [AW-1:0] addr);
      i_run_log = run; i_valid = valid; i_data_to_log = data; i_addr_log = addr;
      i_read_log = m_full;
      @(posedge clk);
      model_step(run, valid, data);
      #1;
   endtask

   task automatic chk_model(input string name);
      chk({name, ".full"}, 32'(o_mem_full), 32'(m_full));
      chk({name, ".busy"}, 32'(o_busy), 32'(m_cap));
      chk({name, ".cnt"}, 32'(o_wr_count), 32'(m_cnt));
      chk({name, ".dout"}, o_data_log, m_full ? m_mem[i_addr_log] : '0);
   endtask

   initial begin
      // Table: start capture, 16 strobes of 0x100+k reading addr 5, then 3 strobes past full.
      tbl[0] = '{1, 0, 32'h0, 4'd5, 0, 1, 0, 32'h0};
      for (int k = 1; k <= 16; k++)
         tbl[k] = '{0, 1, 32'h100 + 32'(k - 1), 4'd5, (k == 16), (k < 16), k,
                    (k == 16) ? 32'h105 : 32'h0};
      for (int k = 17; k < 20; k++)
         tbl[k] = '{0, 1, 32'hDEAD0000 + 32'(k), 4'd0, 1, 0, 16, 32'h100};

      i_rst_n = 1'b0; i_run_log = 0; i_read_log = 0; i_valid = 0;
      i_addr_log = '0; i_data_to_log = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.full", 32'(o_mem_full), 0);
      chk("rst.busy", 32'(o_busy), 0);
      chk("rst.cnt", 32'(o_wr_count), 0);
      chk("rst.dout", o_data_log, 0);
      i_rst_n = 1'b1;

      // Strobes while idle are ignored.
      repeat (3) cyc(0, 1, 32'hA5, 4'd0);
      chk("idle.cnt", 32'(o_wr_count), 0);
      chk("idle.busy", 32'(o_busy), 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].run, tbl[i].valid, tbl[i].data, tbl[i].addr);
         chk($sformatf("tbl%0d.full", i), 32'(o_mem_full), 32'(tbl[i].e_full));
         chk($sformatf("tbl%0d.busy", i), 32'(o_busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d.cnt", i), 32'(o_wr_count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d.dout", i), o_data_log, tbl[i].e_dout);
      end
      cyc(0, 0, 0, 4'd15);
      chk("full.addr15", o_data_log, 32'h10F);

      // Restart from full: mem_full drops next cycle, reads return zero in capture.
      cyc(1, 0, 0, 4'd3);
      chk("restart.full", 32'(o_mem_full), 0);
      chk("restart.busy", 32'(o_busy), 1);
      for (int a = 0; a < 4; a++) begin
         i_addr_log = 4'(a * 5); #1;
         chk($sformatf("cap.dout%0d", a), o_data_log, 0);
      end

      // Mid-capture restart coinciding with a strobe at count 7.
      for (int k = 0; k < 7; k++) cyc(0, 1, 32'h200 + 32'(k), 4'd0);
      chk("mid.cnt7", 32'(o_wr_count), 7);
      cyc(1, 1, 32'h5555, 4'd0);
      chk("mid.cnt0", 32'(o_wr_count), 0);
      chk("mid.full", 32'(o_mem_full), 0);
      cyc(0, 1, 32'hBEEF, 4'd0);
      for (int k = 1; k < 16; k++) cyc(0, 1, 32'h300 + 32'(k), 4'd0);
      chk("mid.done", 32'(o_mem_full), 1);
      chk("mid.addr0", o_data_log, 32'hBEEF);
      i_addr_log = 4'd1; #1;
      chk("mid.addr1", o_data_log, 32'h301);

      // Asynchronous reset between edges at count 9.
      cyc(1, 0, 0, 4'd0);
      for (int k = 0; k < 9; k++) cyc(0, 1, 32'h400 + 32'(k), 4'd0);
      chk("arst.cnt9", 32'(o_wr_count), 9);
      #2 i_rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.cnt", 32'(o_wr_count), 0);
      chk("arst.busy", 32'(o_busy), 0);
      chk("arst.full", 32'(o_mem_full), 0);
      #2 i_rst_n = 1'b1;
      repeat (4) cyc(0, 1, 32'h777, 4'd0);
      chk("arst.idle_cnt", 32'(o_wr_count), 0);
      chk("arst.idle_busy", 32'(o_busy), 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0), $urandom,
             4'($urandom_range(0, DEPTH - 1)));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
